// File: rtl/if_prefetch_buf_if.sv
// Fetch-stage bundle: ROM request/response, flush redirect, and the ID-side valid/ready head.
interface if_prefetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [INST_W-1:0] rom_data_i;
    logic              flush_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic              id_valid_o;
    logic              id_ready_i;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic [CNT_W-1:0]  fifo_count_o;

    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_count_o,
        input  rom_data_i, flush_i, flush_pc_i, id_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fifo_count_o,
        output rom_data_i, flush_i, flush_pc_i, id_ready_i
    );
endinterface

// File: rtl/if_prefetch_buf.sv
// Instruction fetch with DEPTH-entry prefetch FIFO; ROM request in cycle n reaches ID in cycle n+2.
// Issue is credit-gated (count + inflight - pop < DEPTH), so ID stalls throttle fetch without overflow.
module if_prefetch_buf #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    if_prefetch_buf_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic             head_vld;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CNT_W:0]   used;

    always_comb begin
        head_vld = (count != '0);
        pop      = head_vld & bus.id_ready_i;
        push     = inflight & ~bus.flush_i;
        // Entries that will be occupied once everything already requested has landed.
        used     = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue    = ~rst & ~bus.flush_i & (used < (CNT_W+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (bus.flush_i) begin
            pc       <= bus.flush_pc_i;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(PC_STEP);
                inflight_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            inst_mem[wr_ptr] <= bus.rom_data_i;
        end
    end

    assign bus.rom_ce_o     = issue;
    assign bus.rom_addr_o   = pc;
    assign bus.id_valid_o   = head_vld;
    assign bus.id_pc_o      = head_vld ? pc_mem[rd_ptr]   : '0;
    assign bus.id_inst_o    = head_vld ? inst_mem[rd_ptr] : '0;
    assign bus.fifo_count_o = count;
endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf; ROM model returns addr | 0x1000 one cycle after the request.
module tb_if_prefetch_buf;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    if_prefetch_buf_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) bus ();

    if_prefetch_buf #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data_i <= bus.rom_addr_o | 32'h1000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst            = 1'b1;
        bus.flush_i    = 1'b0;
        bus.flush_pc_i = '0;
        bus.id_ready_i = rdy;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ce"},    64'(bus.rom_ce_o),     64'd0);
        chk({tag, "_addr"},  64'(bus.rom_addr_o),   64'd0);
        chk({tag, "_valid"}, 64'(bus.id_valid_o),   64'd0);
        chk({tag, "_pc"},    64'(bus.id_pc_o),      64'd0);
        chk({tag, "_inst"},  64'(bus.id_inst_o),    64'd0);
        chk({tag, "_count"}, 64'(bus.fifo_count_o), 64'd0);
    endtask

    initial begin
        int          nreq;
        int          delivered;
        logic [31:0] exp_pc;
        logic        prev_stall;
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;

        rst            = 1'b1;
        bus.flush_i    = 1'b0;
        bus.flush_pc_i = '0;
        bus.id_ready_i = 1'b1;
        #1;
        chk_reset_outputs("rst0");

        // 1: streaming after reset release
        do_reset(1'b1);
        chk("t1_ce_c0",   64'(bus.rom_ce_o),   64'd1);
        chk("t1_addr_c0", 64'(bus.rom_addr_o), 64'h0);
        chk("t1_vld_c0",  64'(bus.id_valid_o), 64'd0);
        next();
        chk("t1_addr_c1", 64'(bus.rom_addr_o), 64'h4);
        chk("t1_vld_c1",  64'(bus.id_valid_o), 64'd0);
        next();
        chk("t1_vld_c2",  64'(bus.id_valid_o), 64'd1);
        chk("t1_pc_c2",   64'(bus.id_pc_o),    64'h0);
        chk("t1_inst_c2", 64'(bus.id_inst_o),  64'h1000);
        chk("t1_addr_c2", 64'(bus.rom_addr_o), 64'h8);
        chk("t1_cnt_c2",  64'(bus.fifo_count_o), 64'd1);
        for (int i = 1; i < 5; i++) begin
            next();
            chk("t1_stream_vld", 64'(bus.id_valid_o), 64'd1);
            chk("t1_stream_pc",  64'(bus.id_pc_o),    64'(4 * i));
        end

        // 2: ID stalled from the start fills exactly DEPTH entries
        do_reset(1'b0);
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next();
            if (bus.rom_ce_o) begin
                chk("t2_req_addr", 64'(bus.rom_addr_o), 64'(4 * nreq));
                nreq++;
            end
        end
        chk("t2_nreq",  64'(nreq), 64'd4);
        chk("t2_count", 64'(bus.fifo_count_o), 64'd4);
        chk("t2_head",  64'(bus.id_pc_o), 64'h0);
        bus.id_ready_i = 1'b1;
        #1;
        chk("t2_resume_ce",   64'(bus.rom_ce_o),   64'd1);
        chk("t2_resume_addr", 64'(bus.rom_addr_o), 64'h10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            chk("t2_drain_vld", 64'(bus.id_valid_o), 64'd1);
            chk("t2_drain_pc",  64'(bus.id_pc_o),    64'(4 * i));
        end

        // 3: flush with count=3 and a response in flight
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) next();
        chk("t3_pre_count", 64'(bus.fifo_count_o), 64'd3);
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h200;
        #1;
        chk("t3_flush_ce", 64'(bus.rom_ce_o), 64'd0);
        next();
        bus.flush_i    = 1'b0;
        bus.id_ready_i = 1'b1;
        #1;
        chk("t3_count", 64'(bus.fifo_count_o), 64'd0);
        chk("t3_vld",   64'(bus.id_valid_o),   64'd0);
        chk("t3_ce",    64'(bus.rom_ce_o),     64'd1);
        chk("t3_addr",  64'(bus.rom_addr_o),   64'h200);
        next();
        chk("t3_vld_c1", 64'(bus.id_valid_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            next();
            chk("t3_pc",   64'(bus.id_pc_o),   64'(32'h200 + 4 * i));
            chk("t3_inst", 64'(bus.id_inst_o), 64'((32'h200 + 4 * i) | 32'h1000));
        end

        // 4: ready toggling, ordering and head stability
        do_reset(1'b1);
        exp_pc     = 32'h0;
        delivered  = 0;
        prev_stall = 1'b0;
        prev_pc    = '0;
        prev_inst  = '0;
        for (int i = 0; i < 400 && delivered < 64; i++) begin
            if (i > 0) next();
            bus.id_ready_i = (i % 2 == 0);
            #1;
            chk("t4_cnt_le_depth", 64'(bus.fifo_count_o <= 3'd4), 64'd1);
            if (prev_stall) begin
                chk("t4_hold_pc",   64'(bus.id_pc_o),   64'(prev_pc));
                chk("t4_hold_inst", 64'(bus.id_inst_o), 64'(prev_inst));
            end
            if (bus.id_valid_o && bus.id_ready_i) begin
                chk("t4_pc",   64'(bus.id_pc_o),   64'(exp_pc));
                chk("t4_inst", 64'(bus.id_inst_o), 64'(exp_pc | 32'h1000));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_stall = bus.id_valid_o && !bus.id_ready_i;
            prev_pc    = bus.id_pc_o;
            prev_inst  = bus.id_inst_o;
        end
        chk("t4_delivered", 64'(delivered), 64'd64);

        // 5: PC wraps past the top of the address space
        next();
        bus.id_ready_i = 1'b1;
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'hFFFF_FFF8;
        #1;
        chk("t5_flush_ce", 64'(bus.rom_ce_o), 64'd0);
        next();
        bus.flush_i = 1'b0;
        #1;
        chk("t5_addr_c0", 64'(bus.rom_addr_o), 64'hFFFF_FFF8);
        next();
        chk("t5_addr_c1", 64'(bus.rom_addr_o), 64'hFFFF_FFFC);
        next();
        chk("t5_addr_c2", 64'(bus.rom_addr_o), 64'h0);
        chk("t5_pc_c2",   64'(bus.id_pc_o),    64'hFFFF_FFF8);
        next();
        chk("t5_pc_c3",   64'(bus.id_pc_o),    64'hFFFF_FFFC);
        next();
        chk("t5_vld_c4",  64'(bus.id_valid_o), 64'd1);
        chk("t5_pc_c4",   64'(bus.id_pc_o),    64'h0);
        chk("t5_inst_c4", 64'(bus.id_inst_o),  64'h1000);

        // 6: asynchronous reset mid-stream
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) next();
        chk("t6_pre_count", 64'(bus.fifo_count_o), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        next();
        next();
        rst            = 1'b0;
        bus.id_ready_i = 1'b1;
        #1;
        chk("t6_restart_ce",   64'(bus.rom_ce_o),   64'd1);
        chk("t6_restart_addr", 64'(bus.rom_addr_o), 64'h0);
        next();
        next();
        chk("t6_restart_vld", 64'(bus.id_valid_o), 64'd1);
        chk("t6_restart_pc",  64'(bus.id_pc_o),    64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
